// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline.
// Shadows EX/MEM/WB destinations and counts stall/flush events.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_de,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic             use_rs1_de,
  input  logic             use_rs2_de,
  input  logic [4:0]       rd_de,
  input  logic             RUWr_de,
  input  logic             is_load_de,
  input  logic             br_taken_ex,
  output logic             stall_fe,
  output logic             stall_de,
  output logic             flush_fe,
  output logic             flush_de,
  output logic [1:0]       fwdA_sel,
  output logic [1:0]       fwdB_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_st_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
  } mw_st_t;

  ex_st_t ex_q, ex_d;
  mw_st_t mem_q, mem_d;
  mw_st_t wb_q, wb_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic branch_ex;
  logic lu;
  logic hit1;
  logic hit2;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input mw_st_t     mem,
    input mw_st_t     wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem.valid && mem.wr && mem.rd != 5'd0 && mem.rd == rs)
      sel = 2'b01;
    else if (wb.valid && wb.wr && wb.rd != 5'd0 && wb.rd == rs)
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    branch_ex = br_taken_ex & ex_q.valid;
    hit1 = use_rs1_de && (rs1_de == ex_q.rd);
    hit2 = use_rs2_de && (rs2_de == ex_q.rd);
    lu = valid_de & ex_q.valid & ex_q.load
       & (ex_q.rd != 5'd0) & (hit1 | hit2);
  end

  // Branch outranks load-use: the dependent instruction is killed anyway.
  always_comb begin
    stall_fe = 1'b0;
    flush_fe = 1'b0;
    flush_de = 1'b0;
    priority case (1'b1)
      rst: begin
        flush_fe = 1'b1;
        flush_de = 1'b1;
      end
      branch_ex: begin
        flush_fe = 1'b1;
        flush_de = 1'b1;
      end
      lu: begin
        stall_fe = 1'b1;
        flush_de = 1'b1;
      end
      default: ;
    endcase
    stall_de = stall_fe;
  end

  always_comb begin
    fwdA_sel = 2'b00;
    fwdB_sel = 2'b00;
    if (!rst) begin
      fwdA_sel = fwd_sel(ex_q.rs1, mem_q, wb_q);
      fwdB_sel = fwd_sel(ex_q.rs2, mem_q, wb_q);
    end
  end

  always_comb begin
    ex_d = '0;
    if (!flush_de && valid_de) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = rd_de;
      ex_d.wr    = RUWr_de;
      ex_d.load  = is_load_de;
      ex_d.rs1   = rs1_de;
      ex_d.rs2   = rs2_de;
    end
    mem_d.valid = ex_q.valid;
    mem_d.rd    = ex_q.rd;
    mem_d.wr    = ex_q.wr;
    wb_d        = mem_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu && !branch_ex)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch_ex)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Expected control outputs are queued per driven cycle.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic       sfe;
    logic       sde;
    logic       ffe;
    logic       fde;
    logic [1:0] fa;
    logic [1:0] fb;
  } out_t;

  logic             clk;
  logic             rst;
  logic             valid_de;
  logic [4:0]       rs1_de;
  logic [4:0]       rs2_de;
  logic             use_rs1_de;
  logic             use_rs2_de;
  logic [4:0]       rd_de;
  logic             RUWr_de;
  logic             is_load_de;
  logic             br_taken_ex;
  logic             stall_fe;
  logic             stall_de;
  logic             flush_fe;
  logic             flush_de;
  logic [1:0]       fwdA_sel;
  logic [1:0]       fwdB_sel;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .valid_de(valid_de),
    .rs1_de(rs1_de),
    .rs2_de(rs2_de),
    .use_rs1_de(use_rs1_de),
    .use_rs2_de(use_rs2_de),
    .rd_de(rd_de),
    .RUWr_de(RUWr_de),
    .is_load_de(is_load_de),
    .br_taken_ex(br_taken_ex),
    .stall_fe(stall_fe),
    .stall_de(stall_de),
    .flush_fe(flush_fe),
    .flush_de(flush_de),
    .fwdA_sel(fwdA_sel),
    .fwdB_sel(fwdB_sel),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;
  out_t exp_q[$];
  out_t got;
  out_t e;

  function automatic stim_t mk(
    input logic v, input logic [4:0] rd,
    input logic wr, input logic ld,
    input logic [4:0] r1, input logic u1,
    input logic [4:0] r2, input logic u2,
    input logic br
  );
    stim_t s;
    s = '{v, rd, wr, ld, r1, u1, r2, u2, br};
    return s;
  endfunction

  function automatic out_t oo(
    input logic sf, input logic sd,
    input logic ff, input logic fd,
    input logic [1:0] a, input logic [1:0] b
  );
    out_t o;
    o = '{sf, sd, ff, fd, a, b};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{stall_fe, stall_de, flush_fe, flush_de, fwdA_sel, fwdB_sel};
    return o;
  endfunction

  task automatic drive(input stim_t s);
    valid_de    = s.v;
    rd_de       = s.rd;
    RUWr_de     = s.wr;
    is_load_de  = s.ld;
    rs1_de      = s.r1;
    use_rs1_de  = s.u1;
    rs2_de      = s.r2;
    use_rs2_de  = s.u2;
    br_taken_ex = s.br;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      drive('0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0);
    @(posedge clk);
    #2;
    exp_q.push_back(oo(0, 0, 1, 1, 0, 0));
    #1;
    got = sample();
    e = exp_q.pop_front();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_out: got %h want %h", got, e);
    end
    n_run++;
    if (stall_count !== '0 || flush_count !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0",
               stall_count, flush_count);
    end
    exp_stall = '0;
    exp_flush = '0;
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_raw_fwd();
    stim_t st[$];
    out_t  eo[$];
    stim_t add5;
    stim_t sub5;
    add5 = mk(1, 5, 1, 0, 1, 1, 2, 1, 0);
    sub5 = mk(1, 6, 1, 0, 5, 1, 5, 1, 0);
    st = '{add5, sub5, '0,
           mk(1, 5, 1, 0, 3, 1, 4, 1, 0), '0, sub5, '0,
           mk(1, 5, 1, 0, 0, 1, 0, 1, 0),
           mk(1, 5, 1, 0, 0, 1, 0, 1, 0), sub5, '0, '0};
    eo = '{oo(0, 0, 0, 0, 0, 0), oo(0, 0, 0, 0, 0, 0),
           oo(0, 0, 0, 0, 1, 1), oo(0, 0, 0, 0, 0, 0),
           oo(0, 0, 0, 0, 0, 0), oo(0, 0, 0, 0, 0, 0),
           oo(0, 0, 0, 0, 2, 2), oo(0, 0, 0, 0, 0, 0),
           oo(0, 0, 0, 0, 0, 0), oo(0, 0, 0, 0, 0, 0),
           oo(0, 0, 0, 0, 1, 1), oo(0, 0, 0, 0, 0, 0)};
    foreach (st[i]) begin
      @(posedge clk);
      #2;
      drive(st[i]);
      exp_q.push_back(eo[i]);
      #1;
      got = sample();
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL raw_fwd[%0d]: got %h want %h", i, got, e);
      end
    end
    idle(3);
  endtask

  task automatic test_load_use();
    stim_t st[$];
    out_t  eo[$];
    stim_t addr;
    addr = mk(1, 8, 1, 0, 3, 1, 7, 1, 0);
    st = '{mk(1, 7, 1, 1, 2, 1, 0, 0, 0), addr, addr, '0};
    eo = '{oo(0, 0, 0, 0, 0, 0), oo(1, 1, 0, 1, 0, 0),
           oo(0, 0, 0, 0, 0, 0), oo(0, 0, 0, 0, 0, 2)};
    foreach (st[i]) begin
      @(posedge clk);
      #2;
      drive(st[i]);
      exp_q.push_back(eo[i]);
      #1;
      got = sample();
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %h want %h", i, got, e);
      end
    end
    exp_stall = exp_stall + 1'b1;
    n_run++;
    if (stall_count !== exp_stall) begin
      n_fail++;
      $display("FAIL load_use_cnt: got %0d want %0d",
               stall_count, exp_stall);
    end
    idle(3);
  endtask

  task automatic test_x0();
    stim_t st[$];
    out_t  eo[$];
    stim_t rd0;
    rd0 = mk(1, 9, 1, 0, 0, 1, 0, 1, 0);
    st = '{mk(1, 0, 1, 1, 2, 1, 0, 0, 0), rd0,
           mk(1, 0, 1, 0, 1, 1, 1, 1, 0), rd0, '0, '0};
    foreach (st[i]) begin
      @(posedge clk);
      #2;
      drive(st[i]);
      exp_q.push_back(oo(0, 0, 0, 0, 0, 0));
      #1;
      got = sample();
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL x0[%0d]: got %h want %h", i, got, e);
      end
    end
    n_run++;
    if (stall_count !== exp_stall) begin
      n_fail++;
      $display("FAIL x0_cnt: got %0d want %0d", stall_count, exp_stall);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    out_t  eo[$];
    st = '{mk(1, 10, 1, 0, 1, 1, 2, 1, 0),
           mk(1, 11, 1, 0, 1, 1, 2, 1, 1),
           mk(1, 12, 1, 0, 3, 1, 4, 1, 1), '0};
    eo = '{oo(0, 0, 0, 0, 0, 0), oo(0, 0, 1, 1, 0, 0),
           oo(0, 0, 0, 0, 0, 0), oo(0, 0, 0, 0, 0, 0)};
    foreach (st[i]) begin
      @(posedge clk);
      #2;
      drive(st[i]);
      exp_q.push_back(eo[i]);
      #1;
      got = sample();
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %h want %h", i, got, e);
      end
    end
    exp_flush = exp_flush + 1'b1;
    n_run++;
    if (flush_count !== exp_flush) begin
      n_fail++;
      $display("FAIL branch_cnt: got %0d want %0d",
               flush_count, exp_flush);
    end
    idle(3);
  endtask

  task automatic test_branch_lu();
    stim_t st[$];
    out_t  eo[$];
    st = '{mk(1, 7, 1, 1, 1, 1, 0, 0, 0),
           mk(1, 8, 1, 0, 3, 1, 7, 1, 1), '0};
    eo = '{oo(0, 0, 0, 0, 0, 0), oo(0, 0, 1, 1, 0, 0),
           oo(0, 0, 0, 0, 0, 0)};
    foreach (st[i]) begin
      @(posedge clk);
      #2;
      drive(st[i]);
      exp_q.push_back(eo[i]);
      #1;
      got = sample();
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL br_lu[%0d]: got %h want %h", i, got, e);
      end
    end
    exp_flush = exp_flush + 1'b1;
    n_run++;
    if (stall_count !== exp_stall || flush_count !== exp_flush) begin
      n_fail++;
      $display("FAIL br_lu_cnt: got %0d/%0d want %0d/%0d",
               stall_count, flush_count, exp_stall, exp_flush);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    stim_t addr;
    addr = mk(1, 8, 1, 0, 3, 1, 7, 1, 0);
    @(posedge clk);
    #2;
    drive(mk(1, 7, 1, 1, 1, 1, 0, 0, 0));
    @(posedge clk);
    #2;
    drive(addr);
    exp_q.push_back(oo(1, 1, 0, 1, 0, 0));
    #1;
    got = sample();
    e = exp_q.pop_front();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rmid_stall: got %h want %h", got, e);
    end
    #1;
    rst = 1'b1;
    exp_q.push_back(oo(0, 0, 1, 1, 0, 0));
    #1;
    got = sample();
    e = exp_q.pop_front();
    n_run++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rmid_rst: got %h want %h", got, e);
    end
    @(posedge clk);
    #3;
    exp_stall = '0;
    exp_flush = '0;
    n_run++;
    if (stall_count !== exp_stall || flush_count !== exp_flush) begin
      n_fail++;
      $display("FAIL rmid_cnt: got %0d/%0d want 0/0",
               stall_count, flush_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      drive(i == 0 ? addr : stim_t'('0));
      exp_q.push_back(oo(0, 0, 0, 0, 0, 0));
      #1;
      got = sample();
      e = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rmid_post[%0d]: got %h want %h", i, got, e);
      end
    end
    idle(3);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    drive('0);
    test_reset();
    test_raw_fwd();
    test_load_use();
    test_x0();
    test_back_to_back();
    test_branch_lu();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
